// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: reset PC, trap codes, FIFO entry layout and FSM states.
`timescale 1ns/1ps
package instr_fetch_pkg;

  localparam logic [31:0] FETCH_RESET_PC        = 32'h0000_0000;

  localparam logic [7:0]  TRAP_BAD_INSTRUCTION  = 8'h01;
  localparam logic [7:0]  TRAP_SYSCALL          = 8'h02;
  localparam logic [7:0]  TRAP_FETCH_MISALIGNED = 8'h03;

  localparam int FETCH_DEPTH   = 2;
  localparam int FETCH_ENTRY_W = 65;

  // One buffered fetch: instruction word, its PC, and the misaligned-fetch flag.
  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic        exc;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_DISCARD = 2'd1,
    ST_ERR     = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_queue.sv
// Small register FIFO between fetch and decode; head is visible combinationally.
`timescale 1ns/1ps
module fetch_queue
  import instr_fetch_pkg::*;
#(
  parameter int WIDTH = FETCH_ENTRY_W,
  parameter int DEPTH = FETCH_DEPTH,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] w_entries [DEPTH];
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full queue is only legal when the head leaves in the same cycle.
  assign w_do_pop  = pop & (r_count != '0);
  assign w_do_push = push & ((r_count != CW'(DEPTH)) | w_do_pop);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [WIDTH-1:0] r_data;
      // Entry storage; flush leaves contents alone since the count already hides them.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_data <= '0;
        end else if (w_do_push && !flush && (r_wr_ptr == PW'(gi))) begin
          r_data <= din;
        end
      end
      assign w_entries[gi] = r_data;
    end
  endgenerate

  // Pointer and occupancy bookkeeping; flush dominates push and pop.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = w_entries[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC sequencing, request hold, redirect/discard and misaligned-target trap entry.
`timescale 1ns/1ps
module instr_fetch
  import instr_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] ir_pc,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [7:0]  fetch_exception
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;
  logic         r_hold;        // request was issued last cycle and not yet acked
  logic [31:0]  r_hold_addr;
  logic         r_err_tgt;     // latest redirect target is misaligned
  logic         w_err_tgt_next;
  logic [31:0]  r_err_pc;
  logic [31:0]  w_err_pc_next;
  logic         r_err_enq;     // first ERR cycle: insert the trap entry
  logic         w_err_enq_next;

  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic         w_room;
  fetch_entry_t w_din;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [1:0]   w_count;
  logic         w_unused;

  fetch_queue #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FETCH_DEPTH)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign w_unused = &{1'b0, w_count};

  assign ir_valid        = !w_empty;
  assign ir              = w_head.ir;
  assign ir_pc           = w_head.pc;
  assign fetch_exception = w_head.exc ? TRAP_FETCH_MISALIGNED : 8'h00;
  assign w_pop           = ir_valid & ir_ready;
  assign w_room          = !w_full | w_pop;

  // Address never depends on ir_ready: a held request keeps its own address, otherwise the PC.
  assign imem_addr = r_hold ? r_hold_addr : r_pc;
  assign imem_req  = !rst & (r_hold | ((r_state == ST_RUN) & w_room));

  // Next-state, PC and queue control; redirect overrides every other event.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_err_tgt_next = r_err_tgt;
    w_err_pc_next  = r_err_pc;
    w_err_enq_next = 1'b0;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_din          = '{ir: imem_rdata, pc: r_pc, exc: 1'b0};

    if (redirect_en) begin
      w_flush        = 1'b1;
      w_pc_next      = redirect_pc;
      w_err_tgt_next = |redirect_pc[1:0];
      w_err_pc_next  = redirect_pc;
      if (imem_req && !imem_ack) begin
        w_state_next = ST_DISCARD;
      end else if (|redirect_pc[1:0]) begin
        w_state_next   = ST_ERR;
        w_err_enq_next = 1'b1;
      end else begin
        w_state_next = ST_RUN;
      end
    end else begin
      case (r_state)
        ST_RUN: begin
          if (imem_req && imem_ack) begin
            w_push    = 1'b1;
            w_pc_next = r_pc + 32'd4;
          end
        end
        ST_DISCARD: begin
          if (imem_req && imem_ack) begin
            if (r_err_tgt) begin
              w_state_next   = ST_ERR;
              w_err_enq_next = 1'b1;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end
        ST_ERR: begin
          if (r_err_enq) begin
            w_push = 1'b1;
            w_din  = '{ir: 32'h0, pc: r_err_pc, exc: 1'b1};
          end
        end
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  // State register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_pc        <= FETCH_RESET_PC;
      r_hold      <= 1'b0;
      r_hold_addr <= FETCH_RESET_PC;
      r_err_tgt   <= 1'b0;
      r_err_pc    <= FETCH_RESET_PC;
      r_err_enq   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_pc        <= w_pc_next;
      r_hold      <= imem_req & !imem_ack;
      r_hold_addr <= imem_addr;
      r_err_tgt   <= w_err_tgt_next;
      r_err_pc    <= w_err_pc_next;
      r_err_enq   <= w_err_enq_next;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a negedge monitor predicts queue contents and request addresses.
`timescale 1ns/1ps
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic [7:0]  fetch_exception;

  instr_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .ir              (ir),
    .ir_pc           (ir_pc),
    .ir_valid        (ir_valid),
    .ir_ready        (ir_ready),
    .fetch_exception (fetch_exception)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state, owned by the monitor only.
  logic [64:0] exp_q [$];
  logic [64:0] e;
  logic [31:0] m_pc;
  logic        m_stale;
  logic        m_err;
  logic        m_prev_open;
  logic [31:0] m_prev_addr;

  // Monitor: compare dequeues against predictions, then record this cycle's effects.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_pc        = FETCH_RESET_PC;
      m_stale     = 1'b0;
      m_err       = 1'b0;
      m_prev_open = 1'b0;
    end else begin
      if (m_prev_open) begin
        check_val("hold_req", {31'd0, imem_req}, 32'd1);
        check_val("hold_addr", imem_addr, m_prev_addr);
      end
      if (!redirect_en && ir_valid && ir_ready) begin
        if (exp_q.size() == 0) begin
          check_val("sb_unexpected_valid", {31'd0, ir_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_val("sb_ir", ir, e[64:33]);
          check_val("sb_pc", ir_pc, e[32:1]);
          check_val("sb_exc", {24'd0, fetch_exception}, e[0] ? {24'd0, TRAP_FETCH_MISALIGNED} : 32'd0);
          $display("[TB] deq pc=%h ir=%h exc=%h", ir_pc, ir, fetch_exception);
        end
      end
      if (imem_req && !m_stale) check_val("req_addr", imem_addr, m_pc);
      if (m_err && !m_stale && !redirect_en) check_val("err_noreq", {31'd0, imem_req}, 32'd0);
      if (redirect_en) begin
        exp_q.delete();
        m_stale = imem_req && !imem_ack;
        m_pc    = redirect_pc;
        m_err   = |redirect_pc[1:0];
        if (m_err && !m_stale) exp_q.push_back({32'h0, redirect_pc, 1'b1});
      end else if (imem_req && imem_ack) begin
        if (m_stale) begin
          m_stale = 1'b0;
          if (m_err) exp_q.push_back({32'h0, m_pc, 1'b1});
        end else begin
          exp_q.push_back({mem_word(m_pc), m_pc, 1'b0});
          m_pc = m_pc + 32'd4;
        end
      end
      m_prev_open = imem_req && !imem_ack;
      m_prev_addr = imem_addr;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    imem_ack    = 1'b0;
    ir_ready    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    step(2);
    rst = 1'b0;
  endtask

  int cnt;

  initial begin
    rst         = 1'b1;
    imem_ack    = 1'b0;
    ir_ready    = 1'b0;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    step(2);
    @(negedge clk);
    check_val("rst_valid", {31'd0, ir_valid}, 32'd0);
    check_val("rst_req", {31'd0, imem_req}, 32'd0);
    check_val("rst_ir", ir, 32'd0);
    check_val("rst_irpc", ir_pc, 32'd0);
    check_val("rst_exc", {24'd0, fetch_exception}, 32'd0);
    @(posedge clk); #1;

    // Streaming after reset release.
    rst = 1'b0; imem_ack = 1'b1; ir_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("t36_addr", imem_addr, 32'(i * 4));
      check_val("t36_valid", {31'd0, ir_valid}, (i > 0) ? 32'd1 : 32'd0);
      if (i > 0) check_val("t36_irpc", ir_pc, 32'((i - 1) * 4));
      @(posedge clk); #1;
    end

    // Decode stall: exactly two words accepted, then resume.
    do_reset();
    imem_ack = 1'b1; ir_ready = 1'b0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (imem_req && imem_ack) cnt++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("t37_count", 32'(cnt), 32'd2);
    check_val("t37_req", {31'd0, imem_req}, 32'd0);
    check_val("t37_irpc", ir_pc, 32'd0);
    check_val("t37_ir", ir, mem_word(32'd0));
    @(posedge clk); #1;
    ir_ready = 1'b1;
    step(6);

    // Redirect while the request at 8 is outstanding.
    do_reset();
    ir_ready = 1'b1; imem_ack = 1'b1;
    step(2);
    imem_ack = 1'b0;
    step(1);
    redirect_en = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    check_val("t38_addr_r", imem_addr, 32'h8);
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    check_val("t38_addr_h", imem_addr, 32'h8);
    check_val("t38_valid_h", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    imem_ack = 1'b1;
    @(negedge clk);
    check_val("t38_addr_a", imem_addr, 32'h8);
    check_val("t38_valid_a", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t38_addr_n", imem_addr, 32'h100);
    check_val("t38_valid_n", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t38_irpc", ir_pc, 32'h100);
    @(posedge clk); #1;

    // Misaligned redirect: trap entry, no requests until the next redirect.
    ir_ready = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h102;
    step(1);
    redirect_en = 1'b0;
    @(negedge clk);
    check_val("t39_req1", {31'd0, imem_req}, 32'd0);
    check_val("t39_valid1", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_val("t39_valid", {31'd0, ir_valid}, 32'd1);
      check_val("t39_irpc", ir_pc, 32'h102);
      check_val("t39_ir", ir, 32'h0);
      check_val("t39_exc", {24'd0, fetch_exception}, 32'h03);
      check_val("t39_req", {31'd0, imem_req}, 32'd0);
      @(posedge clk); #1;
    end
    ir_ready = 1'b1;
    step(3);
    imem_ack = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h200;
    step(1);
    redirect_en = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    check_val("t39_resume_req", {31'd0, imem_req}, 32'd1);
    check_val("t39_resume_addr", imem_addr, 32'h200);
    @(posedge clk); #1;
    step(3);

    // Redirect with ack and a full queue in the same cycle.
    do_reset();
    ir_ready = 1'b0; imem_ack = 1'b1;
    step(4);
    ir_ready = 1'b1; redirect_en = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    check_val("t40_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk); #1;
    redirect_en = 1'b0;
    @(negedge clk);
    check_val("t40_valid", {31'd0, ir_valid}, 32'd0);
    check_val("t40_addr", imem_addr, 32'h300);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t40_irpc", ir_pc, 32'h300);
    @(posedge clk); #1;

    // Reset in the middle of a request at the top of the address space.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_en = 1'b0; imem_ack = 1'b0;
    @(negedge clk);
    check_val("t41_addr_top", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    rst = 1'b1;
    step(1);
    rst = 1'b0; imem_ack = 1'b1;
    @(negedge clk);
    check_val("t41_addr_rst", imem_addr, 32'h0);
    check_val("t41_valid_rst", {31'd0, ir_valid}, 32'd0);
    @(posedge clk); #1;
    step(2);

    // Wrap-around without reset.
    redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(1);
    redirect_en = 1'b0;
    @(negedge clk);
    check_val("t41_wrap_a", imem_addr, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t41_wrap_b", imem_addr, 32'h0);
    check_val("t41_wrap_irpc", ir_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    @(negedge clk);
    check_val("t41_wrap_irpc0", ir_pc, 32'h0);
    @(posedge clk); #1;

    // Drain: every predicted word must have been delivered.
    imem_ack = 1'b0; ir_ready = 1'b1;
    step(4);
    check_val("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port imem_req, output, 1: fetch request to instruction memory.
REQ-004 SHALL have port imem_addr, output, 32: word address of the current request.
REQ-005 SHALL have port imem_ack, input, 1: memory accepts the request and returns imem_rdata in the same cycle.
REQ-006 SHALL have port imem_rdata, input, 32: fetched instruction word.
REQ-007 SHALL have port redirect_en, input, 1: branch/jump/trap redirect from the execute stage.
REQ-008 SHALL have port redirect_pc, input, 32: new fetch PC.
REQ-009 SHALL have port ir, output, 32: instruction word presented to the decoder.
REQ-010 SHALL have port ir_pc, output, 32: PC of ir.
REQ-011 SHALL have port ir_valid, output, 1: ir, ir_pc and fetch_exception are valid.
REQ-012 SHALL have port ir_ready, input, 1: decode stage accepts; low means stall.
REQ-013 SHALL have port fetch_exception, output, 8: 0, or TRAP_FETCH_MISALIGNED on an exception entry.

Function
REQ-014 SHALL buffer fetched words in a 2-entry FIFO; each entry holds {ir, pc, exc flag}; ir/ir_pc/fetch_exception SHALL be driven from the FIFO head.
REQ-015 SHALL assert ir_valid iff the FIFO is non-empty; dequeue happens when ir_valid && ir_ready.
REQ-016 SHALL hold ir, ir_pc, fetch_exception stable while ir_valid && !ir_ready.
REQ-017 SHALL implement the states RUN, DISCARD and ERR.
REQ-018 In RUN, SHALL assert imem_req when the FIFO count is < 2, or when the count is 2 and a dequeue occurs in that cycle; imem_addr = pc.
REQ-019 Once imem_req is asserted, SHALL hold imem_req high and imem_addr unchanged until imem_ack, in every state.
REQ-020 On imem_ack in RUN, SHALL enqueue {imem_rdata, pc, 0} and set pc <= pc + 4, with 32-bit wrap-around (32'hFFFFFFFC + 4 = 0).
REQ-021 Latency: an ack in cycle N SHALL make the word visible on ir in cycle N+1; sustained throughput SHALL be 1 instruction/cycle when imem_ack and ir_ready are held high.
REQ-022 Simultaneous enqueue and dequeue SHALL keep the count unchanged, and SHALL be permitted when the FIFO is full.
REQ-023 redirect_en SHALL have priority over all other events and SHALL have the following effects:
- flush the FIFO, so ir_valid = 0 in the next cycle;
- set pc <= redirect_pc;
- drop any imem_rdata acked in the same cycle.
REQ-024 If a request is outstanding without ack in the redirect cycle, SHALL enter DISCARD.
REQ-025 In DISCARD, SHALL keep the old request until imem_ack, drop its data, then go to RUN (or to ERR per REQ-026); a further redirect in DISCARD SHALL only update pc and the ERR target.
REQ-026 If redirect_pc[1:0] != 0, SHALL go to ERR once no request is outstanding.
REQ-027 On entering ERR, SHALL enqueue a single entry {32'h0, redirect_pc, 1}; fetch_exception = TRAP_FETCH_MISALIGNED while that entry is at the head.
REQ-028 In ERR, SHALL issue no requests; SHALL leave ERR only on redirect_en, applying REQ-023 to REQ-026.
REQ-029 ir_ready SHALL have no combinational path to imem_addr.

Reset
REQ-030 On rst, SHALL set the following:
- pc = FETCH_RESET_PC (32'h00000000);
- state = RUN;
- FIFO empty;
- ir_valid = 0, imem_req = 0, ir = 0, ir_pc = 0, fetch_exception = 0.
REQ-031 rst SHALL take priority over redirect_en.
REQ-032 An outstanding request aborted by rst SHALL be abandoned; the memory side is reset by the same rst.
REQ-033 imem_req SHALL first assert in the cycle after rst is deasserted.

Structure
REQ-034 FETCH_RESET_PC and TRAP_FETCH_MISALIGNED (8'h03) SHALL live in the shared defines header, next to TRAP_BAD_INSTRUCTION and TRAP_SYSCALL.
REQ-035 The FIFO SHALL be a sub-module fetch_queue:
- parameterised width (65 here), depth 2;
- ports push, pop, flush, full, empty, count;
- flush dominates push.

Verification
REQ-036 Reset release, imem_ack tied 1, ir_ready 1 -> imem_addr 0, 4, 8 on consecutive cycles; ir_pc = 0, 4, 8 starting one cycle after the first ack.
REQ-037 ir_ready = 0 with acks available -> exactly 2 entries accepted, imem_req drops, ir holds the PC 0 word; ir_ready = 1 -> resumes with no word lost or duplicated.
REQ-038 Redirect to 32'h00000100 while a request at 32'h00000008 is unacked for 3 cycles -> imem_addr stays 8 until ack, that data is discarded, next request is to 32'h100, and no ir_valid occurs in between.
REQ-039 Redirect to 32'h00000102 -> one entry with ir_pc = 32'h102, ir = 0, fetch_exception = 8'h03; no imem_req until redirect to 32'h200, after which fetching resumes at 32'h200.
REQ-040 redirect_en and imem_ack in the same cycle with a full FIFO -> acked data is dropped, the FIFO is empty next cycle, and the next request goes to redirect_pc.
REQ-041 Start from pc = 32'hFFFFFFFC and assert rst mid-request -> after rst release, imem_addr = 0 and the FIFO is empty; a separate run without rst shows wrap to 0 after 32'hFFFFFFFC.
